serial_rx: RTL and testbench
============================

# serial_rx

Asynchronous 8N1 UART receiver that turns the FPGA `rx` pin into byte-wide strobes. It sits directly upstream of the message printer, which expects a stream of `rx_data` bytes, each qualified by a one-cycle `new_rx_data` pulse. The receiver does three things: it synchronises the pin, validates each start bit at mid-bit, samples eight data bits LSB-first at bit centres, and checks the stop bit. A bad stop bit raises a framing-error strobe and never emits the byte.

## Interface
- `CLK_PER_BIT`, default 100. Clock cycles per serial bit (50 MHz / 500 kbaud). Must be ≥ 4.
- `HALF_BIT`, default `CLK_PER_BIT/2`. Cycles from the start-bit edge to the start-bit centre check. This is a derived localparam and is not overridable.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `rx`  in  1  raw serial line, asynchronous to `clk`; idle level is 1.
- `rx_data`  out  8  last correctly framed byte; holds until the next good byte arrives.
- `new_rx_data`  out  1  one-cycle pulse; `rx_data` is valid in the same cycle.
- `framing_err`  out  1  one-cycle pulse when the stop bit is sampled as 0.

## Operation
- **Synchroniser:** two flops, `rx` → `rx_m` → `rx_s`. Both reset to 1. All state-machine decisions use `rx_s` only.
- **Counter:** `ctr`, width `$clog2(CLK_PER_BIT)`. Reset value 0.
- **Bit index:** `bit_idx`, 3 bits. Reset value 0.
- **Shift register:** `shreg`, 8 bits. Reset value 0.
- **IDLE**
  - `rx_s` = 0 → go to START with `ctr` = 0.
  - Otherwise stay in IDLE.
- **START**
  - While `ctr` < `HALF_BIT`−1: increment `ctr`.
  - At `ctr` = `HALF_BIT`−1 with `rx_s` = 0 → go to DATA, `ctr` = 0, `bit_idx` = 0.
  - At `ctr` = `HALF_BIT`−1 with `rx_s` = 1 → glitch; return to IDLE with no output.
- **DATA**
  - While `ctr` < `CLK_PER_BIT`−1: increment `ctr`.
  - At `ctr` = `CLK_PER_BIT`−1: shift `rx_s` into `shreg` from the MSB side (LSB-first reception), clear `ctr`, and increment `bit_idx`.
  - After the sample with `bit_idx` = 7 → go to STOP.
- **STOP**
  - At `ctr` = `CLK_PER_BIT`−1, sample `rx_s`.
  - `rx_s` = 1 → `rx_data` ← `shreg`, pulse `new_rx_data`, go to IDLE.
  - `rx_s` = 0 → pulse `framing_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE**
  - Stay while `rx_s` = 0, which covers line breaks.
  - Go to IDLE on the first cycle `rx_s` = 1.
- **Back-to-back frames:** the return to IDLE happens at the stop-bit centre, so a start bit immediately after the stop bit is caught with no gap.
- **`new_rx_data` and `framing_err`** are never high together and are never high for more than one cycle.
- **Reset values of all outputs:** `rx_data` = 0x00, `new_rx_data` = 0, `framing_err` = 0. State resets to IDLE.
- **Reset mid-frame:** the partial byte is discarded and there are no strobes. After `rst` deasserts, reception restarts from IDLE on the next 1→0 transition seen on `rx_s`.

## Timing
- Let E0 be the first rising edge at which `rx_m` captures 0.
- E1: `rx_s` becomes 0.
- E2: state moves to START.
- Start-bit check at E(2+`HALF_BIT`).
- Data bit k (k = 0..7) sampled at E(2+`HALF_BIT`+(k+1)·`CLK_PER_BIT`).
- Stop bit sampled at E(2+`HALF_BIT`+9·`CLK_PER_BIT`).
  - `new_rx_data` (or `framing_err`) is registered on that edge and is high for exactly the following cycle.
  - With `CLK_PER_BIT` = 16 this is E154.
- Sampling tolerance: the sample point drifts at most ±0.5 bit over 10 bits. The block must receive correctly with transmitter rate error up to ±3 %.
- Outputs are registered; there are no combinational paths from `rx`.

## Test plan
- **Single byte:** `CLK_PER_BIT` = 16, send 0xB1 (start, bits 1,0,0,0,1,1,0,1, stop) → exactly one `new_rx_data` pulse at E154 with `rx_data` = 0xB1; `framing_err` stays 0.
- **Back-to-back frames:** send 0x08 then 0x00 with zero idle between frames → two pulses exactly 160 cycles apart, carrying `rx_data` = 0x08 then 0x00.
- **Glitch rejection:** pull `rx` low for 3 cycles, then high → no strobes and state back in IDLE. A subsequent 0x5A is received correctly.
- **Framing error:** receive 0x41, then send 0x7E with the stop bit forced to 0 and the line held low for 40 more cycles.
  - Required: one `framing_err` pulse at the stop sample, no `new_rx_data`, and `rx_data` still 0x41.
  - After the line returns high, a following 0x33 is received correctly.
- **Reset mid-frame:** assert `rst` = 0 asynchronously during data bit 4 of 0xFF.
  - Required: outputs go to 0 immediately, and no strobe occurs for the aborted frame.
  - After release, 0xC3 is received correctly.
- **Baud skew:** send 0xA5 at a bit period of 15 and then 17 cycles (±6 % on `CLK_PER_BIT` = 16 only reaches the ±3 % requirement boundary at ~16.5; use 15.5/16.5 via alternating periods) → `rx_data` = 0xA5 both times, no `framing_err`.

Source files
------------

// File: rtl/serial_rx_if.sv
// Receive-side bundle of serial_rx: the last good byte plus its two strobes.
//   rx_data     : last correctly framed byte, held until the next good byte
//   new_rx_data : one-cycle pulse, rx_data valid in the same cycle
//   framing_err : one-cycle pulse when a stop bit is sampled low
// master drives the bundle (the receiver); slave observes it (the consumer).
interface serial_rx_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       framing_err;

  modport master (output rx_data, output new_rx_data, output framing_err);
  modport slave  (input  rx_data, input  new_rx_data, input  framing_err);
endinterface

// File: rtl/serial_rx.sv
// 8N1 UART receiver: synchronises rx, checks the start bit at mid-bit,
// samples eight data bits LSB-first at bit centres, then checks the stop bit.
// A good frame updates rx_data with a new_rx_data pulse; a low stop bit gives
// a framing_err pulse and the byte is dropped.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   rx  : raw serial line, asynchronous to clk, idles high
//   bus : serial_rx_if master (rx_data, new_rx_data, framing_err), all registered
module serial_rx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  serial_rx_if.master  bus
);

  localparam int unsigned HALF_BIT = CLK_PER_BIT / 2;
  localparam int unsigned CTR_W    = $clog2(CLK_PER_BIT);

  localparam logic [CTR_W-1:0] CTR_HALF_LAST = CTR_W'(HALF_BIT - 1);
  localparam logic [CTR_W-1:0] CTR_BIT_LAST  = CTR_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             new_rx_data_q, new_rx_data_d;
  logic             framing_err_q, framing_err_d;
  logic             rx_m, rx_s;

  // Two-flop synchroniser; resets to the idle line level so reset cannot fake a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ctr_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      new_rx_data_q <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      new_rx_data_q <= new_rx_data_d;
      framing_err_q <= framing_err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    new_rx_data_d = 1'b0;
    framing_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          ctr_d   = '0;
        end
      end

      // A start bit that is high again at mid-bit is treated as a glitch.
      START: begin
        if (ctr_q == CTR_HALF_LAST) begin
          ctr_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end

      // LSB arrives first, so each bit enters at the MSB and walks down.
      DATA: begin
        if (ctr_q == CTR_BIT_LAST) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          ctr_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end

      // Leaving at the stop-bit centre lets a back-to-back start bit be caught.
      STOP: begin
        if (ctr_q == CTR_BIT_LAST) begin
          ctr_d = '0;
          if (rx_s) begin
            rx_data_d     = shreg_q;
            new_rx_data_d = 1'b1;
            state_d       = IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end

      // Ride out a line break before hunting for the next start bit.
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.new_rx_data = new_rx_data_q;
  assign bus.framing_err = framing_err_q;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx at CLK_PER_BIT = 16: directed frames from the test plan
// plus a randomized run, scored against a frame-level reference model.
module tb_serial_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Cycles from driving the start bit (at a negedge) to the negedge on which
  // the strobe is visible: one edge to E0, then E(2+HALF+9*CPB).
  localparam int STROBE_LAT = 1 + 2 + HALF + 9 * CPB;

  typedef struct {
    int         cyc;   // -1 means timing not checked
    bit         ferr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  int   cyc = 0;

  int   vectors     = 0;
  int   miscompares = 0;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] last_good = 8'h00;
  logic       prev_strobe = 1'b0;

  serial_rx_if bus_if ();

  serial_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe monitor: records every strobe and checks exclusivity and width.
  always @(negedge clk) begin
    logic strobe;
    ev_t  e;
    strobe = bus_if.new_rx_data | bus_if.framing_err;
    if (strobe) begin
      check("strobe_exclusive", 32'(bus_if.new_rx_data & bus_if.framing_err), 32'd0);
      check("strobe_width", 32'(prev_strobe), 32'd0);
      e.cyc  = cyc;
      e.ferr = bus_if.framing_err;
      e.data = bus_if.rx_data;
      obs_q.push_back(e);
    end
    prev_strobe = strobe;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame; even-indexed bits last p0 cycles, odd-indexed bits p1.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int p0, input int p1, input bit timed);
    ev_t        e;
    logic [9:0] fr;
    e.cyc  = timed ? cyc + STROBE_LAT : -1;
    e.ferr = !stop_ok;
    e.data = stop_ok ? b : last_good;
    exp_q.push_back(e);
    if (stop_ok) last_good = b;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat ((i % 2 == 0) ? p0 : p1) @(negedge clk);
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_kind"}, 32'(obs_q[i].ferr), 32'(exp_q[i].ferr));
      check({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
      if (exp_q[i].cyc >= 0)
        check({tag, "_time"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
    end
    check({tag, "_rx_data_hold"}, 32'(bus_if.rx_data), 32'(last_good));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;

    rx  = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(bus_if.rx_data), 32'h00);
    check("reset_new_rx_data", 32'(bus_if.new_rx_data), 32'd0);
    check("reset_framing_err", 32'(bus_if.framing_err), 32'd0);
    rst = 1'b1;
    idle(10);

    // Single byte with exact strobe timing.
    send_frame(8'hB1, 1'b1, CPB, CPB, 1'b1);
    idle(10);
    compare_events("single");

    // Back-to-back frames, no idle gap: strobes 160 cycles apart.
    send_frame(8'h08, 1'b1, CPB, CPB, 1'b1);
    send_frame(8'h00, 1'b1, CPB, CPB, 1'b1);
    idle(10);
    compare_events("b2b");

    // Short low glitch is rejected; a following byte still arrives on time.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    compare_events("glitch");
    send_frame(8'h5A, 1'b1, CPB, CPB, 1'b1);
    idle(10);
    compare_events("after_glitch");

    // Framing error followed by a held-low line, then recovery.
    send_frame(8'h41, 1'b1, CPB, CPB, 1'b1);
    idle(10);
    send_frame(8'h7E, 1'b0, CPB, CPB, 1'b1);
    repeat (40) @(negedge clk);
    idle(20);
    compare_events("framing");
    send_frame(8'h33, 1'b1, CPB, CPB, 1'b1);
    idle(10);
    compare_events("after_framing");

    // Asynchronous reset in the middle of data bit 4 of 0xFF.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + HALF) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_rx_data", 32'(bus_if.rx_data), 32'h00);
    check("midreset_new_rx_data", 32'(bus_if.new_rx_data), 32'd0);
    check("midreset_framing_err", 32'(bus_if.framing_err), 32'd0);
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(200);
    compare_events("midreset");
    send_frame(8'hC3, 1'b1, CPB, CPB, 1'b1);
    idle(10);
    compare_events("after_reset");

    // Baud skew: average periods 15.5 and 16.5 cycles.
    send_frame(8'hA5, 1'b1, 15, 16, 1'b0);
    idle(20);
    send_frame(8'hA5, 1'b1, 16, 17, 1'b0);
    idle(20);
    compare_events("skew");

    // Randomized frames with occasional bad stop bits and random gaps.
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, CPB, CPB, 1'b1);
      if (ok) idle($urandom_range(0, 12));
      else    idle($urandom_range(4, 20));
    end
    idle(10);
    compare_events("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
